// File: rtl/mux4_rr_sched_pkg.sv
// Shared definitions for the four-way round-robin mux scheduler:
// arbiter state encoding, default tenure limit and a one-hot helper.
package mux4_rr_sched_pkg;

    // Arbiter states: IDLE picks a winner, GRANT moves words for the owner.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Number of requesters sharing the mux.
    localparam int NREQ = 4;

    // Default number of words one requester may move per grant tenure.
    localparam int MAX_HOLD_DEFAULT = 4;

    // Turn a 2-bit requester index into a 4-bit one-hot grant vector.
    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational round-robin picker. It scans the four request bits starting
// at ptr (ptr, ptr+1, ... mod 4) and reports the first set one as win_idx.
// When no request is set, any is low and win_idx just echoes ptr.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win_idx,
    output logic       any
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] off;

    // Doubling the vector lets a plain part-select act as a rotate, so that
    // req_rot[k] is the request of source (ptr + k) mod 4.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: 4];
    assign any     = |req;

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        off = 2'd0;
        if (req_rot[0]) begin
            off = 2'd0;
        end else if (req_rot[1]) begin
            off = 2'd1;
        end else if (req_rot[2]) begin
            off = 2'd2;
        end else if (req_rot[3]) begin
            off = 2'd3;
        end
        win_idx = ptr + off;
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one registered 4:1 data mux between four
// requesters. A grant lasts until the owner drops its request or has moved
// MAX_HOLD words; every release passes through one IDLE cycle and moves the
// priority pointer just past the released owner.
module mux4_rr_sched
    import mux4_rr_sched_pkg::*;
#(
    parameter int DW       = 8,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          dout_vld
);

    // Tenure limit at counter width; MAX_HOLD is restricted to 1..15.
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    // Arbitration stage registers.
    state_t        state_p0;
    state_t        state_nxt;
    logic [3:0]    gnt_p0;
    logic [3:0]    gnt_nxt;
    logic [1:0]    sel_p0;
    logic [1:0]    sel_nxt;
    logic [1:0]    ptr_p0;
    logic [1:0]    ptr_nxt;
    logic [3:0]    cnt_p0;
    logic [3:0]    cnt_nxt;
    logic [3:0]    cnt_inc;

    // Output data stage registers.
    logic [DW-1:0] dout_p1;
    logic [DW-1:0] dout_nxt;
    logic          vld_p1;
    logic          vld_nxt;

    // Picker results and the currently selected data word.
    logic [1:0]    win_idx;
    logic          any;
    logic [DW-1:0] din_mux;
    logic          owner_req;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_p0),
        .win_idx (win_idx),
        .any     (any)
    );

    // Shared 4:1 data mux steered by the registered select.
    always_comb begin
        din_mux = din0;
        unique case (sel_p0)
            2'd0: din_mux = din0;
            2'd1: din_mux = din1;
            2'd2: din_mux = din2;
            2'd3: din_mux = din3;
        endcase
    end

    assign owner_req = req[sel_p0];
    assign cnt_inc   = cnt_p0 + 4'd1;

    // Next-state and next-output logic of the arbiter; everything holds by default.
    always_comb begin
        state_nxt = state_p0;
        gnt_nxt   = gnt_p0;
        sel_nxt   = sel_p0;
        ptr_nxt   = ptr_p0;
        cnt_nxt   = cnt_p0;
        dout_nxt  = dout_p1;
        vld_nxt   = 1'b0;

        unique case (state_p0)
            ST_IDLE: begin
                if (any) begin
                    gnt_nxt   = onehot4(win_idx);
                    sel_nxt   = win_idx;
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (owner_req) begin
                    dout_nxt = din_mux;
                    vld_nxt  = 1'b1;
                    cnt_nxt  = cnt_inc;
                    if (cnt_inc == HOLD_LIM) begin
                        gnt_nxt   = 4'd0;
                        ptr_nxt   = sel_p0 + 2'd1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    // Owner withdrew: release without a transfer.
                    gnt_nxt   = 4'd0;
                    ptr_nxt   = sel_p0 + 2'd1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Arbitration stage: state, grant, select, pointer and tenure counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= ST_IDLE;
            gnt_p0   <= 4'd0;
            sel_p0   <= 2'd0;
            ptr_p0   <= 2'd0;
            cnt_p0   <= 4'd0;
        end else begin
            state_p0 <= state_nxt;
            gnt_p0   <= gnt_nxt;
            sel_p0   <= sel_nxt;
            ptr_p0   <= ptr_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    // Output data stage: captured word and its valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            dout_p1 <= dout_nxt;
            vld_p1  <= vld_nxt;
        end
    end

    assign gnt      = gnt_p0;
    assign sel      = sel_p0;
    assign busy     = |gnt_p0;
    assign dout     = dout_p1;
    assign dout_vld = vld_p1;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Bench for mux4_rr_sched: a MAX_HOLD=4 and a MAX_HOLD=1 instance share the
// same stimulus and are compared every cycle against a behavioural model,
// alongside directed checks for each scenario.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'd0;
    logic [7:0] din0 = 8'd0, din1 = 8'd0, din2 = 8'd0, din3 = 8'd0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b;
    logic [7:0] dout_a, dout_b;
    logic       vld_a, vld_b;
    logic [15:0] obs_a, obs_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux4_rr_sched #(.DW(8), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .dout(dout_a), .dout_vld(vld_a)
    );

    mux4_rr_sched #(.DW(8), .MAX_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .dout(dout_b), .dout_vld(vld_b)
    );

    assign obs_a = {gnt_a, sel_a, busy_a, dout_a, vld_a};
    assign obs_b = {gnt_b, sel_b, busy_b, dout_b, vld_b};

    // Behavioural model: owner<0 means nobody holds the mux.
    typedef struct {
        int         owner;
        int         ptr;
        int         cnt;
        int         sel;
        logic [7:0] dout;
        logic       vld;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t mreset();
        mstate_t s;
        s.owner = -1; s.ptr = 0; s.cnt = 0; s.sel = 0; s.dout = 8'd0; s.vld = 1'b0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int hold, logic [3:0] r, logic [31:0] d);
        mstate_t n = s;
        if (s.owner < 0) begin
            n.vld = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int i = (s.ptr + k) % 4;
                if (r[i] && n.owner < 0) begin
                    n.owner = i; n.sel = i; n.cnt = 0;
                end
            end
        end else if (r[s.owner]) begin
            n.dout = d[8*s.owner +: 8];
            n.vld  = 1'b1;
            n.cnt  = s.cnt + 1;
            if (n.cnt == hold) begin
                n.owner = -1; n.ptr = (s.owner + 1) % 4;
            end
        end else begin
            n.vld = 1'b0; n.owner = -1; n.ptr = (s.owner + 1) % 4;
        end
        return n;
    endfunction

    function automatic logic [15:0] mvec(mstate_t s);
        logic [3:0] g;
        g = (s.owner < 0) ? 4'd0 : (4'b0001 << s.owner);
        return {g, 2'(s.sel), (s.owner >= 0), s.dout, s.vld};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, 4, req, {din3, din2, din1, din0});
            mb <= mstep(mb, 1, req, {din3, din2, din1, din0});
        end
    end

    task automatic drive_din();
        din0 = 8'($urandom); din1 = 8'($urandom);
        din2 = 8'($urandom); din3 = 8'($urandom);
    endtask

    task automatic do_reset();
        req = 4'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'd0; drive_din();
        repeat (3) @(negedge clk);
        checks++; if (obs_a !== 16'd0) begin errors++; $display("FAIL reset_a got=%h want=0000", obs_a); end
        checks++; if (obs_b !== 16'd0) begin errors++; $display("FAIL reset_b got=%h want=0000", obs_b); end
        checks++; if (obs_a !== mvec(ma)) begin errors++; $display("FAIL reset_model got=%h want=%h", obs_a, mvec(ma)); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_source();
        int nv = 0;
        do_reset();
        req = 4'b0100; drive_din(); din2 = 8'hA5;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++; if (obs_a !== mvec(ma)) begin errors++; $display("FAIL single_model_a c=%0d got=%h want=%h", c, obs_a, mvec(ma)); end
            checks++; if (obs_b !== mvec(mb)) begin errors++; $display("FAIL single_model_b c=%0d got=%h want=%h", c, obs_b, mvec(mb)); end
            if (vld_a) begin
                nv++;
                checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL single_dout got=%h want=a5", dout_a); end
            end
            if (c == 1) begin
                checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL single_first_gnt got=%b want=0100", gnt_a); end
            end
            if (c == 5) begin
                checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL single_release got=%b want=0000", gnt_a); end
            end
            if (c == 6) begin
                checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL single_regrant got=%b want=0100", gnt_a); end
            end
            drive_din(); din2 = 8'hA5;
        end
        checks++; if (nv != 4) begin errors++; $display("FAIL single_vld_count got=%0d want=4", nv); end
    endtask

    task automatic test_all_requesting();
        int   order[$];
        int   idle = 0;
        logic prev = 1'b0;
        do_reset();
        req = 4'b1111; drive_din();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++; if (obs_a !== mvec(ma)) begin errors++; $display("FAIL all_model_a c=%0d got=%h want=%h", c, obs_a, mvec(ma)); end
            checks++; if (obs_b !== mvec(mb)) begin errors++; $display("FAIL all_model_b c=%0d got=%h want=%h", c, obs_b, mvec(mb)); end
            if (busy_a && !prev) order.push_back(int'(sel_a));
            if (!busy_a) idle++;
            prev = busy_a;
            drive_din();
        end
        checks++; if (order.size() != 8) begin errors++; $display("FAIL all_grant_count got=%0d want=8", order.size()); end
        for (int k = 0; k < order.size(); k++) begin
            checks++; if (order[k] != k % 4) begin errors++; $display("FAIL all_order k=%0d got=%0d want=%0d", k, order[k], k % 4); end
        end
        checks++; if (idle != 8) begin errors++; $display("FAIL all_idle_cycles got=%0d want=8", idle); end
    endtask

    task automatic test_early_drop();
        int         nv = 0;
        logic [7:0] d1;
        do_reset();
        req = 4'b1010; drive_din(); d1 = din1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (obs_a !== mvec(ma)) begin errors++; $display("FAIL drop_model_a c=%0d got=%h want=%h", c, obs_a, mvec(ma)); end
            checks++; if (obs_b !== mvec(mb)) begin errors++; $display("FAIL drop_model_b c=%0d got=%h want=%h", c, obs_b, mvec(mb)); end
            if (vld_a) begin
                nv++;
                checks++; if (dout_a !== d1) begin errors++; $display("FAIL drop_dout got=%h want=%h", dout_a, d1); end
            end
            if (c == 1) begin
                checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL drop_first_gnt got=%b want=0010", gnt_a); end
            end
            if (c == 4) begin
                checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL drop_idle got=%b want=0000", gnt_a); end
            end
            if (c == 5) begin
                checks++; if (gnt_a !== 4'b1000) begin errors++; $display("FAIL drop_next_gnt got=%b want=1000", gnt_a); end
            end
            if (c == 3) req = 4'b1000;
            drive_din(); din1 = d1;
        end
        checks++; if (nv != 2) begin errors++; $display("FAIL drop_vld_count got=%0d want=2", nv); end
        req = 4'd0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100; drive_din();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({gnt_a, busy_a, vld_a} !== 6'd0) begin errors++; $display("FAIL async_rst_a got=%b want=000000", {gnt_a, busy_a, vld_a}); end
        checks++; if (obs_b !== 16'd0) begin errors++; $display("FAIL async_rst_b got=%h want=0000", obs_b); end
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL async_regrant got=%b want=0001", gnt_a); end
        checks++; if (obs_a !== mvec(ma)) begin errors++; $display("FAIL async_model_a got=%h want=%h", obs_a, mvec(ma)); end
        checks++; if (obs_b !== mvec(mb)) begin errors++; $display("FAIL async_model_b got=%h want=%h", obs_b, mvec(mb)); end
        req = 4'd0;
    endtask

    task automatic test_max_hold1();
        int   order[$];
        int   idle = 0;
        logic prev = 1'b0;
        do_reset();
        req = 4'b0110; drive_din();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (obs_b !== mvec(mb)) begin errors++; $display("FAIL hold1_model c=%0d got=%h want=%h", c, obs_b, mvec(mb)); end
            if (busy_b && !prev) order.push_back(int'(sel_b));
            if (!busy_b) idle++;
            prev = busy_b;
            drive_din();
        end
        checks++; if (order.size() != 4) begin errors++; $display("FAIL hold1_grant_count got=%0d want=4", order.size()); end
        for (int k = 0; k < order.size(); k++) begin
            checks++; if (order[k] != 1 + (k % 2)) begin errors++; $display("FAIL hold1_order k=%0d got=%0d want=%0d", k, order[k], 1 + (k % 2)); end
        end
        checks++; if (idle != 4) begin errors++; $display("FAIL hold1_idle got=%0d want=4", idle); end
        req = 4'd0;
    endtask

    task automatic test_ignore_nongranted();
        int   nv = 0;
        logic saw0 = 1'b0;
        do_reset();
        req = 4'b1000; drive_din();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++; if (obs_a !== mvec(ma)) begin errors++; $display("FAIL ignore_model_a c=%0d got=%h want=%h", c, obs_a, mvec(ma)); end
            checks++; if (obs_b !== mvec(mb)) begin errors++; $display("FAIL ignore_model_b c=%0d got=%h want=%h", c, obs_b, mvec(mb)); end
            if (gnt_a[0] || (vld_a && sel_a == 2'd0)) saw0 = 1'b1;
            if (vld_a) nv++;
            if (c == 1) begin
                checks++; if (gnt_a !== 4'b1000) begin errors++; $display("FAIL ignore_first_gnt got=%b want=1000", gnt_a); end
                req = 4'b1001;
            end
            if (c == 2) req = 4'b1000;
            if (c == 5) req = 4'b0000;
            drive_din();
        end
        checks++; if (saw0 !== 1'b0) begin errors++; $display("FAIL ignore_src0_served got=%b want=0", saw0); end
        checks++; if (nv != 4) begin errors++; $display("FAIL ignore_vld_count got=%0d want=4", nv); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            drive_din();
            @(negedge clk);
            checks++; if (obs_a !== mvec(ma)) begin errors++; $display("FAIL random_model_a c=%0d got=%h want=%h", c, obs_a, mvec(ma)); end
            checks++; if (obs_b !== mvec(mb)) begin errors++; $display("FAIL random_model_b c=%0d got=%h want=%h", c, obs_b, mvec(mb)); end
        end
        req = 4'd0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_all_requesting();
        test_early_drop();
        test_async_reset();
        test_max_hold1();
        test_ignore_nongranted();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
